// File: rtl/spi_cmd_pkg.sv
// ---------------------------------------------------------------------------
// spi_cmd_pkg
// Shared definitions for the SPI command parser:
//   - FSM state encodings (legacy-compatible localparam constants)
//   - command / response byte codes
//   - address of the optional error counter
//   - frame checksum helper
// Optional feature macro used by the design: PARSER_ERR_CNT_EN
// ---------------------------------------------------------------------------
package spi_cmd_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_HUNT = 3'd0;
    localparam state_t ST_CMD  = 3'd1;
    localparam state_t ST_ADDR = 3'd2;
    localparam state_t ST_DATA = 3'd3;
    localparam state_t ST_CHK  = 3'd4;
    localparam state_t ST_EXEC = 3'd5;
    localparam state_t ST_RESP = 3'd6;

    localparam logic [7:0] CMD_WRITE    = 8'h01;
    localparam logic [7:0] CMD_READ     = 8'h02;
    localparam logic [7:0] RSP_ACK      = 8'h06;
    localparam logic [7:0] RSP_NAK      = 8'h15;
    localparam logic [3:0] ERR_CNT_ADDR = 4'hF;

    // Frame check byte: XOR of the three payload bytes.
    function automatic logic [7:0] calc_chk(
        input logic [7:0] cmd,
        input logic [7:0] addr,
        input logic [7:0] data
    );
        return cmd ^ addr ^ data;
    endfunction

endpackage

// File: rtl/spi_cmd_regfile.sv
// ---------------------------------------------------------------------------
// spi_cmd_regfile
// 16 x 8-bit register file for the SPI command parser.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (clears all registers)
//   we           : write enable (one cycle)
//   addr         : register address, shared by write and read ports
//   wdata        : write data
//   rdata        : combinational read data for addr
//   reg0         : live value of register 0
//   err_pulse    : (PARSER_ERR_CNT_EN only) frame error pulse to count
// With PARSER_ERR_CNT_EN defined, address 4'hF maps to a saturating 8-bit
// error counter: reads return the count, writes clear it.
// Without it, address 4'hF is an ordinary register.
// ---------------------------------------------------------------------------
module spi_cmd_regfile
    import spi_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [3:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic [7:0] reg0
`ifdef PARSER_ERR_CNT_EN
    ,
    input  logic       err_pulse
`endif
);

    logic [7:0] regs_r [16];
    logic       reg_we_s;

    // Register write qualifier; the counter address is diverted when enabled.
    always_comb begin
        reg_we_s = we;
`ifdef PARSER_ERR_CNT_EN
        if (addr == ERR_CNT_ADDR) begin
            reg_we_s = 1'b0;
        end else begin
            reg_we_s = we;
        end
`endif
    end

    // Register array storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else if (reg_we_s) begin
            regs_r[addr] <= wdata;
        end
    end

`ifdef PARSER_ERR_CNT_EN
    logic [7:0] err_cnt_r;

    // Saturating frame-error counter; a write to its address clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= 8'h00;
        end else if (we && (addr == ERR_CNT_ADDR)) begin
            err_cnt_r <= 8'h00;
        end else if (err_pulse && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'h01;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end
`endif

    // Combinational read port.
    always_comb begin
        rdata = regs_r[addr];
`ifdef PARSER_ERR_CNT_EN
        if (addr == ERR_CNT_ADDR) begin
            rdata = err_cnt_r;
        end else begin
            rdata = regs_r[addr];
        end
`endif
    end

    assign reg0 = regs_r[0];

endmodule

// File: rtl/spi_cmd_parser.sv
// ---------------------------------------------------------------------------
// spi_cmd_parser
// Frames SPI bytes into 5-byte packets (SYNC, CMD, ADDR, DATA, CHK), executes
// register read/write commands on a 16x8 register file and pushes ACK / NAK /
// read-data response bytes into the UART TX FIFO.
// Ports:
//   system_clk       : system clock
//   reset_n          : asynchronous active-low reset
//   spi_rx_data      : byte from spi_slave
//   spi_data_ready   : level, byte valid until acknowledged
//   spi_read_ack     : one-cycle pulse consuming the byte
//   tx_fifo_data_in  : response byte to UART TX FIFO
//   tx_fifo_write_en : one-cycle write strobe
//   tx_fifo_full     : UART TX FIFO full
//   reg0_out         : live value of register 0
//   frame_error      : one-cycle pulse on any NAK or inter-byte timeout
// Optional feature macro: PARSER_ERR_CNT_EN (error counter at address 4'hF).
// ---------------------------------------------------------------------------
module spi_cmd_parser
    import spi_cmd_pkg::*;
#(
    parameter int         CLOCK_FREQUENCY = 27000000,
    parameter int         TIMEOUT_CYCLES  = CLOCK_FREQUENCY / 100,
    parameter logic [7:0] SYNC_BYTE       = 8'hA5
)(
    input  logic       system_clk,
    input  logic       reset_n,
    input  logic [7:0] spi_rx_data,
    input  logic       spi_data_ready,
    output logic       spi_read_ack,
    output logic [7:0] tx_fifo_data_in,
    output logic       tx_fifo_write_en,
    input  logic       tx_fifo_full,
    output logic [7:0] reg0_out,
    output logic       frame_error
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_r;
    logic             taken_r;
    logic [7:0]       cmd_r;
    logic [7:0]       addr_r;
    logic [7:0]       data_r;
    logic [7:0]       chk_r;
    logic [CNT_W-1:0] to_cnt_r;
    logic             rsp_two_r;
    logic             rsp_idx_r;
    logic [7:0]       rsp0_r;
    logic [7:0]       rsp1_r;
    logic             ack_r;
    logic [7:0]       tx_data_r;
    logic             tx_we_r;
    logic             ferr_r;

    logic             in_frame_s;
    logic             take_s;
    logic             to_expired_s;
    logic             exec_wr_s;
    logic             exec_rd_s;
    logic             reg_we_s;
    logic             emit_s;
    logic [7:0]       rd_data_s;
    logic [7:0]       reg0_s;

    // Byte intake, timeout and emit qualifiers.
    always_comb begin
        in_frame_s   = (state_r == ST_CMD) || (state_r == ST_ADDR) ||
                       (state_r == ST_DATA) || (state_r == ST_CHK);
        take_s       = spi_data_ready && !taken_r &&
                       ((state_r == ST_HUNT) || in_frame_s);
        to_expired_s = in_frame_s && !take_s && (to_cnt_r == TO_LAST);
        // A strobe is never issued in the cycle right after another one.
        emit_s       = (state_r == ST_RESP) && !tx_fifo_full && !tx_we_r;
    end

    // Command decision, evaluated while in EXEC; checksum and address range
    // take priority over the command code.
    always_comb begin
        exec_wr_s = 1'b0;
        exec_rd_s = 1'b0;
        if ((chk_r == calc_chk(cmd_r, addr_r, data_r)) && (addr_r[7:4] == 4'h0)) begin
            if (cmd_r == CMD_WRITE) begin
                exec_wr_s = 1'b1;
            end else if (cmd_r == CMD_READ) begin
                exec_rd_s = 1'b1;
            end else begin
                exec_wr_s = 1'b0;
                exec_rd_s = 1'b0;
            end
        end else begin
            exec_wr_s = 1'b0;
            exec_rd_s = 1'b0;
        end
        reg_we_s = (state_r == ST_EXEC) && exec_wr_s;
    end

    // SPI handshake: ack pulse and taken flag (cleared once ready drops).
    always_ff @(posedge system_clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_r   <= 1'b0;
            taken_r <= 1'b0;
        end else begin
            ack_r <= take_s;
            if (!spi_data_ready) begin
                taken_r <= 1'b0;
            end else if (take_s) begin
                taken_r <= 1'b1;
            end else begin
                taken_r <= taken_r;
            end
        end
    end

    // Inter-byte timeout counter, only running inside a frame.
    always_ff @(posedge system_clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_r <= '0;
        end else if (!in_frame_s || take_s || to_expired_s) begin
            to_cnt_r <= '0;
        end else begin
            to_cnt_r <= to_cnt_r + CNT_W'(1);
        end
    end

    // Parser FSM with shadow registers and response staging.
    always_ff @(posedge system_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_HUNT;
            cmd_r     <= 8'h00;
            addr_r    <= 8'h00;
            data_r    <= 8'h00;
            chk_r     <= 8'h00;
            rsp_two_r <= 1'b0;
            rsp_idx_r <= 1'b0;
            rsp0_r    <= 8'h00;
            rsp1_r    <= 8'h00;
        end else begin
            case (state_r)
                ST_HUNT: begin
                    // Non-sync bytes are consumed and dropped silently.
                    if (take_s && (spi_rx_data == SYNC_BYTE)) begin
                        state_r <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (take_s) begin
                        cmd_r   <= spi_rx_data;
                        state_r <= ST_ADDR;
                    end else if (to_expired_s) begin
                        state_r <= ST_HUNT;
                    end
                end
                ST_ADDR: begin
                    if (take_s) begin
                        addr_r  <= spi_rx_data;
                        state_r <= ST_DATA;
                    end else if (to_expired_s) begin
                        state_r <= ST_HUNT;
                    end
                end
                ST_DATA: begin
                    if (take_s) begin
                        data_r  <= spi_rx_data;
                        state_r <= ST_CHK;
                    end else if (to_expired_s) begin
                        state_r <= ST_HUNT;
                    end
                end
                ST_CHK: begin
                    if (take_s) begin
                        chk_r   <= spi_rx_data;
                        state_r <= ST_EXEC;
                    end else if (to_expired_s) begin
                        state_r <= ST_HUNT;
                    end
                end
                ST_EXEC: begin
                    rsp_two_r <= exec_rd_s;
                    rsp_idx_r <= 1'b0;
                    rsp0_r    <= (exec_wr_s || exec_rd_s) ? RSP_ACK : RSP_NAK;
                    rsp1_r    <= rd_data_s;
                    state_r   <= ST_RESP;
                end
                ST_RESP: begin
                    if (emit_s) begin
                        if (rsp_idx_r == rsp_two_r) begin
                            state_r <= ST_HUNT;
                        end else begin
                            rsp_idx_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_HUNT;
                end
            endcase
        end
    end

    // TX FIFO write strobe/data and frame error pulse.
    always_ff @(posedge system_clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_we_r   <= 1'b0;
            tx_data_r <= 8'h00;
            ferr_r    <= 1'b0;
        end else begin
            tx_we_r   <= emit_s;
            tx_data_r <= emit_s ? (rsp_idx_r ? rsp1_r : rsp0_r) : 8'h00;
            ferr_r    <= ((state_r == ST_EXEC) && !(exec_wr_s || exec_rd_s)) ||
                         to_expired_s;
        end
    end

    spi_cmd_regfile u_regfile (
        .clk       (system_clk),
        .rst_n     (reset_n),
        .we        (reg_we_s),
        .addr      (addr_r[3:0]),
        .wdata     (data_r),
        .rdata     (rd_data_s),
        .reg0      (reg0_s)
`ifdef PARSER_ERR_CNT_EN
        ,
        .err_pulse (ferr_r)
`endif
    );

    assign spi_read_ack     = ack_r;
    assign tx_fifo_data_in  = tx_data_r;
    assign tx_fifo_write_en = tx_we_r;
    assign frame_error      = ferr_r;
    assign reg0_out         = reg0_s;

endmodule

// File: tb/tb_spi_cmd_parser.sv
// ---------------------------------------------------------------------------
// tb_spi_cmd_parser
// Self-checking bench for spi_cmd_parser. Expected TX bytes are queued when a
// frame is sent and checked by a monitor as strobes appear.
// ---------------------------------------------------------------------------
module tb_spi_cmd_parser;

    localparam int TO = 64;

    logic       clk;
    logic       reset_n;
    logic [7:0] spi_rx_data;
    logic       spi_data_ready;
    logic       spi_read_ack;
    logic [7:0] tx_fifo_data_in;
    logic       tx_fifo_write_en;
    logic       tx_fifo_full;
    logic [7:0] reg0_out;
    logic       frame_error;

    int         errors = 0;
    int         checks = 0;
    int         ack_cnt = 0;
    int         ferr_cnt = 0;
    logic       prev_we = 1'b0;
    logic [7:0] exp_q[$];

    spi_cmd_parser #(
        .CLOCK_FREQUENCY (27000000),
        .TIMEOUT_CYCLES  (TO),
        .SYNC_BYTE       (8'hA5)
    ) dut (
        .system_clk       (clk),
        .reset_n          (reset_n),
        .spi_rx_data      (spi_rx_data),
        .spi_data_ready   (spi_data_ready),
        .spi_read_ack     (spi_read_ack),
        .tx_fifo_data_in  (tx_fifo_data_in),
        .tx_fifo_write_en (tx_fifo_write_en),
        .tx_fifo_full     (tx_fifo_full),
        .reg0_out         (reg0_out),
        .frame_error      (frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run must always terminate.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    // Monitor: scoreboard pop, strobe spacing, full-flag compliance, pulse counts.
    always @(negedge clk) begin
        if (reset_n) begin
            if (spi_read_ack) ack_cnt++;
            if (frame_error) ferr_cnt++;
            if (tx_fifo_write_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected: got %02h, required no strobe", tx_fifo_data_in);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_fifo_data_in !== e) begin
                        errors++;
                        $display("FAIL tx_data: got %02h, required %02h", tx_fifo_data_in, e);
                    end
                end
                checks++;
                if (prev_we) begin
                    errors++;
                    $display("FAIL tx_adjacent: strobe on back-to-back cycles, required gap");
                end
                checks++;
                if (tx_fifo_full !== 1'b0) begin
                    errors++;
                    $display("FAIL tx_while_full: full=%b at strobe, required 0", tx_fifo_full);
                end
            end
            prev_we = tx_fifo_write_en;
        end else begin
            prev_we = 1'b0;
        end
    end

    function automatic logic [7:0] chk_of(input logic [7:0] c, input logic [7:0] a,
                                          input logic [7:0] d);
        return c ^ a ^ d;
    endfunction

    // Present one byte and wait (bounded) for its ack; then drop ready for a cycle.
    task automatic send_byte(input logic [7:0] b);
        int n;
        spi_rx_data    = b;
        spi_data_ready = 1'b1;
        n = 0;
        while (n < 200) begin
            @(posedge clk); #1;
            n++;
            if (spi_read_ack) break;
        end
        checks++;
        if (!spi_read_ack) begin
            errors++;
            $display("FAIL spi_ack: no ack for byte %02h within 200 cycles, required ack", b);
        end
        spi_data_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                              input logic [7:0] d, input logic [7:0] k);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(a);
        send_byte(d);
        send_byte(k);
    endtask

    // Wait (bounded) for all queued response bytes, then idle a few cycles.
    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d bytes outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        spi_rx_data    = 8'h00;
        spi_data_ready = 1'b0;
        tx_fifo_full   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({spi_read_ack, tx_fifo_write_en, frame_error, tx_fifo_data_in, reg0_out} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b we=%b ferr=%b tx=%02h reg0=%02h, required all 0",
                     spi_read_ack, tx_fifo_write_en, frame_error, tx_fifo_data_in, reg0_out);
        end
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({spi_read_ack, tx_fifo_write_en, frame_error} !== 3'd0) begin
            errors++;
            $display("FAIL reset_idle: ack=%b we=%b ferr=%b, required 0", spi_read_ack,
                     tx_fifo_write_en, frame_error);
        end
    endtask

    task automatic test_write();
        int a0, f0;
        a0 = ack_cnt;
        f0 = ferr_cnt;
        exp_q.push_back(8'h06);
        send_frame(8'h01, 8'h03, 8'h5C, 8'h5E);
        // send_byte returns one cycle after the CHK ack: strobe due next cycle.
        @(posedge clk); #1;
        checks++;
        if (tx_fifo_write_en !== 1'b1) begin
            errors++;
            $display("FAIL write_latency: we=%b two cycles after CHK ack, required 1", tx_fifo_write_en);
        end
        wait_drain("write");
        checks++;
        if (ack_cnt - a0 != 5) begin
            errors++;
            $display("FAIL write_acks: got %0d acks, required 5", ack_cnt - a0);
        end
        checks++;
        if (ferr_cnt != f0) begin
            errors++;
            $display("FAIL write_ferr: got %0d pulses, required 0", ferr_cnt - f0);
        end
    endtask

    task automatic test_read();
        exp_q.push_back(8'h06);
        exp_q.push_back(8'h5C);
        send_frame(8'h02, 8'h03, 8'h00, 8'h01);
        wait_drain("read");
    endtask

    task automatic test_bad_chk();
        int f0;
        f0 = ferr_cnt;
        exp_q.push_back(8'h15);
        send_frame(8'h01, 8'h02, 8'h11, 8'h00);
        wait_drain("badchk");
        checks++;
        if (ferr_cnt - f0 != 1) begin
            errors++;
            $display("FAIL badchk_ferr: got %0d pulses, required 1", ferr_cnt - f0);
        end
        // reg2 must still hold its reset value.
        exp_q.push_back(8'h06);
        exp_q.push_back(8'h00);
        send_frame(8'h02, 8'h02, 8'h00, chk_of(8'h02, 8'h02, 8'h00));
        wait_drain("badchk_read");
        // Address out of range is rejected.
        exp_q.push_back(8'h15);
        send_frame(8'h01, 8'h13, 8'h44, chk_of(8'h01, 8'h13, 8'h44));
        wait_drain("badaddr");
        // Unknown command is rejected.
        exp_q.push_back(8'h15);
        send_frame(8'h07, 8'h01, 8'h44, chk_of(8'h07, 8'h01, 8'h44));
        wait_drain("badcmd");
    endtask

    task automatic test_noise();
        int a0;
        a0 = ack_cnt;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (ack_cnt - a0 != 3) begin
            errors++;
            $display("FAIL noise_acks: got %0d acks, required 3", ack_cnt - a0);
        end
        exp_q.push_back(8'h06);
        send_frame(8'h01, 8'h00, 8'h81, 8'h80);
        wait_drain("noise");
        checks++;
        if (reg0_out !== 8'h81) begin
            errors++;
            $display("FAIL noise_reg0: got %02h, required 81", reg0_out);
        end
    endtask

    task automatic test_timeout();
        int n, f0;
        f0 = ferr_cnt;
        send_byte(8'hA5);
        send_byte(8'h01);
        n = 0;
        while (n < TO + 20) begin
            @(posedge clk); #1;
            n++;
            if (frame_error) break;
        end
        checks++;
        if (n != TO - 1 || !frame_error) begin
            errors++;
            $display("FAIL timeout_pulse: frame_error after %0d cycles, required %0d", n, TO - 1);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (ferr_cnt - f0 != 1) begin
            errors++;
            $display("FAIL timeout_count: got %0d pulses, required 1", ferr_cnt - f0);
        end
        exp_q.push_back(8'h06);
        send_frame(8'h01, 8'h01, 8'h07, chk_of(8'h01, 8'h01, 8'h07));
        wait_drain("after_timeout");
    endtask

    task automatic test_backpressure();
        int a0;
        bit seen_we, seen_ack;
        tx_fifo_full = 1'b1;
        exp_q.push_back(8'h06);
        exp_q.push_back(8'h07);
        send_frame(8'h02, 8'h01, 8'h00, chk_of(8'h02, 8'h01, 8'h00));
        a0 = ack_cnt;
        spi_rx_data    = 8'hA5;
        spi_data_ready = 1'b1;
        seen_we  = 1'b0;
        seen_ack = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (tx_fifo_write_en) seen_we = 1'b1;
            if (spi_read_ack) seen_ack = 1'b1;
        end
        checks++;
        if (seen_we) begin
            errors++;
            $display("FAIL bp_strobe: strobe while full, required none");
        end
        checks++;
        if (seen_ack) begin
            errors++;
            $display("FAIL bp_ack: next byte acked during response, required pending");
        end
        tx_fifo_full = 1'b0;
        // Pending A5 is accepted once the response has gone out.
        send_byte(8'hA5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_release: %0d bytes outstanding, required 0", exp_q.size());
        end
        checks++;
        if (ack_cnt - a0 != 1) begin
            errors++;
            $display("FAIL bp_ack_count: got %0d acks, required 1", ack_cnt - a0);
        end
        exp_q.push_back(8'h06);
        exp_q.push_back(8'h07);
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(chk_of(8'h02, 8'h01, 8'h00));
        wait_drain("bp_second");
    endtask

    task automatic test_reset_mid();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h05);
        reset_n        = 1'b0;
        spi_rx_data    = 8'hA5;
        spi_data_ready = 1'b1;
        #2;
        checks++;
        if ({spi_read_ack, tx_fifo_write_en, frame_error, tx_fifo_data_in, reg0_out} !== 19'd0) begin
            errors++;
            $display("FAIL midreset_outputs: ack=%b we=%b ferr=%b tx=%02h reg0=%02h, required all 0",
                     spi_read_ack, tx_fifo_write_en, frame_error, tx_fifo_data_in, reg0_out);
        end
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        // Ready held across reset: the byte is taken afresh as the sync byte.
        exp_q.push_back(8'h06);
        exp_q.push_back(8'h00);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(chk_of(8'h02, 8'h03, 8'h00));
        wait_drain("midreset_read");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_chk();
        test_noise();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
